// File: rtl/alu_rs_if.sv
// Bundle between the ALU reservation station and the rest of the core:
// issue port, flush/enable, the two result broadcasts and the ALU dispatch port.
interface alu_rs_if #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 5
);
  logic              rdy_in;
  logic              clear;
  logic              full;

  logic              issue_valid;
  logic [TYPE_W-1:0] issue_type;
  logic [ROB_W-1:0]  issue_rob_id;
  logic [31:0]       issue_v1;
  logic [31:0]       issue_v2;
  logic              issue_q1_busy;
  logic              issue_q2_busy;
  logic [ROB_W-1:0]  issue_q1;
  logic [ROB_W-1:0]  issue_q2;

  logic              alu_cdb_ready;
  logic [ROB_W-1:0]  alu_cdb_rob_id;
  logic [31:0]       alu_cdb_value;
  logic              lsb_cdb_ready;
  logic [ROB_W-1:0]  lsb_cdb_rob_id;
  logic [31:0]       lsb_cdb_value;

  logic              exe_valid;
  logic [TYPE_W-1:0] exe_type;
  logic [31:0]       exe_r1;
  logic [31:0]       exe_r2;
  logic [ROB_W-1:0]  exe_rob_id;

  modport master (
    output rdy_in, clear,
    output issue_valid, issue_type, issue_rob_id, issue_v1, issue_v2,
    output issue_q1_busy, issue_q2_busy, issue_q1, issue_q2,
    output alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value,
    output lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value,
    input  full, exe_valid, exe_type, exe_r1, exe_r2, exe_rob_id
  );

  modport slave (
    input  rdy_in, clear,
    input  issue_valid, issue_type, issue_rob_id, issue_v1, issue_v2,
    input  issue_q1_busy, issue_q2_busy, issue_q1, issue_q2,
    input  alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value,
    input  lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value,
    output full, exe_valid, exe_type, exe_r1, exe_r2, exe_rob_id
  );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds instructions until both operands are
// captured from the result broadcasts, then dispatches one per cycle by index priority.
module alu_rs #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int TYPE_W  = 5
) (
  input logic   clk_in,
  input logic   rst_in,
  alu_rs_if.slave rs
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [ROB_W-1:0]  rob_id;
    logic [31:0]       v1;
    logic [31:0]       v2;
    logic              q1_busy;
    logic [ROB_W-1:0]  q1;
    logic              q2_busy;
    logic [ROB_W-1:0]  q2;
  } entry_t;

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } operand_t;

  // ALU broadcast wins when both buses carry the awaited tag.
  function automatic operand_t snoop(
    input logic             busy,
    input logic [ROB_W-1:0] tag,
    input logic [31:0]      val,
    input logic             alu_rdy,
    input logic [ROB_W-1:0] alu_tag,
    input logic [31:0]      alu_val,
    input logic             lsb_rdy,
    input logic [ROB_W-1:0] lsb_tag,
    input logic [31:0]      lsb_val
  );
    operand_t r;
    r.busy = busy;
    r.val  = val;
    if (busy && alu_rdy && (tag == alu_tag)) begin
      r.busy = 1'b0;
      r.val  = alu_val;
    end else if (busy && lsb_rdy && (tag == lsb_tag)) begin
      r.busy = 1'b0;
      r.val  = lsb_val;
    end
    return r;
  endfunction

  entry_t              ent_q [RS_SIZE];
  entry_t              ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]  busy_q, busy_d;

  logic                exe_valid_q, exe_valid_d;
  logic [TYPE_W-1:0]   exe_type_q, exe_type_d;
  logic [31:0]         exe_r1_q, exe_r1_d;
  logic [31:0]         exe_r2_q, exe_r2_d;
  logic [ROB_W-1:0]    exe_rob_id_q, exe_rob_id_d;

  logic                free_found, sel_found;
  logic [IDX_W-1:0]    free_idx, sel_idx;
  operand_t            op1, op2;
  entry_t              new_ent;

  always_comb begin
    busy_d       = busy_q;
    ent_d        = ent_q;
    exe_valid_d  = exe_valid_q;
    exe_type_d   = exe_type_q;
    exe_r1_d     = exe_r1_q;
    exe_r2_d     = exe_r2_q;
    exe_rob_id_d = exe_rob_id_q;
    free_found   = 1'b0;
    free_idx     = '0;
    sel_found    = 1'b0;
    sel_idx      = '0;
    op1          = '0;
    op2          = '0;
    new_ent      = '0;

    // Selection uses start-of-cycle state only, so fresh issues/wakeups wait a cycle.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy_q[i] && !ent_q[i].q1_busy && !ent_q[i].q2_busy && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    if (rs.rdy_in) begin
      if (rs.clear) begin
        busy_d      = '0;
        exe_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            op1 = snoop(ent_q[i].q1_busy, ent_q[i].q1, ent_q[i].v1,
                        rs.alu_cdb_ready, rs.alu_cdb_rob_id, rs.alu_cdb_value,
                        rs.lsb_cdb_ready, rs.lsb_cdb_rob_id, rs.lsb_cdb_value);
            op2 = snoop(ent_q[i].q2_busy, ent_q[i].q2, ent_q[i].v2,
                        rs.alu_cdb_ready, rs.alu_cdb_rob_id, rs.alu_cdb_value,
                        rs.lsb_cdb_ready, rs.lsb_cdb_rob_id, rs.lsb_cdb_value);
            ent_d[i].q1_busy = op1.busy;
            ent_d[i].v1      = op1.val;
            ent_d[i].q2_busy = op2.busy;
            ent_d[i].v2      = op2.val;
          end
        end

        if (sel_found) begin
          exe_valid_d      = 1'b1;
          exe_type_d       = ent_q[sel_idx].typ;
          exe_r1_d         = ent_q[sel_idx].v1;
          exe_r2_d         = ent_q[sel_idx].v2;
          exe_rob_id_d     = ent_q[sel_idx].rob_id;
          busy_d[sel_idx]  = 1'b0;
        end else begin
          exe_valid_d = 1'b0;
        end

        if (rs.issue_valid && free_found) begin
          op1 = snoop(rs.issue_q1_busy, rs.issue_q1, rs.issue_v1,
                      rs.alu_cdb_ready, rs.alu_cdb_rob_id, rs.alu_cdb_value,
                      rs.lsb_cdb_ready, rs.lsb_cdb_rob_id, rs.lsb_cdb_value);
          op2 = snoop(rs.issue_q2_busy, rs.issue_q2, rs.issue_v2,
                      rs.alu_cdb_ready, rs.alu_cdb_rob_id, rs.alu_cdb_value,
                      rs.lsb_cdb_ready, rs.lsb_cdb_rob_id, rs.lsb_cdb_value);
          new_ent.typ      = rs.issue_type;
          new_ent.rob_id   = rs.issue_rob_id;
          new_ent.v1       = op1.val;
          new_ent.q1_busy  = op1.busy;
          new_ent.q1       = rs.issue_q1;
          new_ent.v2       = op2.val;
          new_ent.q2_busy  = op2.busy;
          new_ent.q2       = rs.issue_q2;
          ent_d[free_idx]  = new_ent;
          busy_d[free_idx] = 1'b1;
        end
      end
    end
  end

  // Stage boundary: control and dispatch port registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      exe_valid_q  <= 1'b0;
      exe_type_q   <= '0;
      exe_r1_q     <= '0;
      exe_r2_q     <= '0;
      exe_rob_id_q <= '0;
    end else begin
      busy_q       <= busy_d;
      exe_valid_q  <= exe_valid_d;
      exe_type_q   <= exe_type_d;
      exe_r1_q     <= exe_r1_d;
      exe_r2_q     <= exe_r2_d;
      exe_rob_id_q <= exe_rob_id_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign rs.full       = &busy_q;
  assign rs.exe_valid  = exe_valid_q;
  assign rs.exe_type   = exe_type_q;
  assign rs.exe_r1     = exe_r1_q;
  assign rs.exe_r2     = exe_r2_q;
  assign rs.exe_rob_id = exe_rob_id_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: expected dispatches are queued by the stimulus and
// popped by an independent monitor whenever exe_valid is seen.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rs_if #(.ROB_W(4), .TYPE_W(5)) bus ();
  alu_rs #(.RS_SIZE(16), .ROB_W(4), .TYPE_W(5)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rs     (bus)
  );

  typedef struct packed {
    logic [4:0]  typ;
    logic [3:0]  rob;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.exe_valid === 1'b1) begin
      if (q_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dispatch: got rob=%0d r1=%0h r2=%0h want no dispatch",
                 bus.exe_rob_id, bus.exe_r1, bus.exe_r2);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("dispatch", 128'({bus.exe_type, bus.exe_rob_id, bus.exe_r1, bus.exe_r2}), 128'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int typ, input int rob, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.typ = 5'(typ);
    e.rob = 4'(rob);
    e.r1  = r1;
    e.r2  = r2;
    q_exp.push_back(e);
  endtask

  task automatic issue(input int typ, input int rob, input logic [31:0] v1, input logic [31:0] v2,
                       input logic q1b, input int q1, input logic q2b, input int q2);
    bus.issue_valid   = 1'b1;
    bus.issue_type    = 5'(typ);
    bus.issue_rob_id  = 4'(rob);
    bus.issue_v1      = v1;
    bus.issue_v2      = v2;
    bus.issue_q1_busy = q1b;
    bus.issue_q1      = 4'(q1);
    bus.issue_q2_busy = q2b;
    bus.issue_q2      = 4'(q2);
  endtask

  task automatic idle_bus();
    bus.issue_valid   = 1'b0;
    bus.alu_cdb_ready = 1'b0;
    bus.lsb_cdb_ready = 1'b0;
    bus.clear         = 1'b0;
  endtask

  task automatic alu_cdb(input int tag, input logic [31:0] val);
    bus.alu_cdb_ready  = 1'b1;
    bus.alu_cdb_rob_id = 4'(tag);
    bus.alu_cdb_value  = val;
  endtask

  task automatic lsb_cdb(input int tag, input logic [31:0] val);
    bus.lsb_cdb_ready  = 1'b1;
    bus.lsb_cdb_rob_id = 4'(tag);
    bus.lsb_cdb_value  = val;
  endtask

  initial begin
    bus.rdy_in = 1'b1;
    issue(0, 0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 0);
    alu_cdb(0, 32'h0);
    lsb_cdb(0, 32'h0);
    idle_bus();
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Reset state
    chk("rst_exe_valid", 128'(bus.exe_valid), 128'(0));
    chk("rst_exe_type",  128'(bus.exe_type),  128'(0));
    chk("rst_exe_r1",    128'(bus.exe_r1),    128'(0));
    chk("rst_exe_r2",    128'(bus.exe_r2),    128'(0));
    chk("rst_exe_rob",   128'(bus.exe_rob_id), 128'(0));
    chk("rst_full",      128'(bus.full),      128'(0));

    // Both operands ready at issue
    issue(0, 3, 32'd7, 32'd5, 1'b0, 0, 1'b0, 0);
    push(0, 3, 32'd7, 32'd5);
    tick();
    idle_bus();
    chk("t1_not_yet", 128'(bus.exe_valid), 128'(0));
    tick();
    chk("t1_valid", 128'(bus.exe_valid), 128'(1));
    chk("t1_r1",    128'(bus.exe_r1),    128'(7));
    chk("t1_r2",    128'(bus.exe_r2),    128'(5));
    chk("t1_rob",   128'(bus.exe_rob_id), 128'(3));
    tick();
    chk("t1_drop", 128'(bus.exe_valid), 128'(0));

    // Wait on tag 6, wake from the ALU bus
    issue(1, 2, 32'h0, 32'd1, 1'b1, 6, 1'b0, 0);
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_waiting", 128'(bus.exe_valid), 128'(0));
    end
    alu_cdb(6, 32'h10);
    push(1, 2, 32'h10, 32'd1);
    tick();
    idle_bus();
    chk("t2_woken_not_eligible", 128'(bus.exe_valid), 128'(0));
    tick();
    chk("t2_valid", 128'(bus.exe_valid), 128'(1));
    chk("t2_r1",    128'(bus.exe_r1),    128'(32'h10));
    tick();

    // Same-cycle forward from the load bus
    issue(2, 5, 32'd3, 32'h0, 1'b0, 0, 1'b1, 4);
    lsb_cdb(4, 32'hABCD);
    push(2, 5, 32'd3, 32'hABCD);
    tick();
    idle_bus();
    tick();
    chk("t3_valid", 128'(bus.exe_valid), 128'(1));
    chk("t3_r2",    128'(bus.exe_r2),    128'(32'hABCD));
    tick();

    // Both buses carry the awaited tag: ALU value wins
    issue(6, 8, 32'h0, 32'd2, 1'b1, 7, 1'b0, 0);
    alu_cdb(7, 32'h111);
    lsb_cdb(7, 32'h222);
    push(6, 8, 32'h111, 32'd2);
    tick();
    idle_bus();
    tick();
    chk("t3b_alu_wins", 128'(bus.exe_r1), 128'(32'h111));
    tick();

    // Fill all 16 entries on tag 9, then overflow attempt
    for (int i = 0; i < 16; i++) begin
      issue(3, i, 32'h0, 32'(i + 100), 1'b1, 9, 1'b0, 0);
      tick();
    end
    idle_bus();
    chk("t4_full", 128'(bus.full), 128'(1));
    issue(3, 14, 32'hDEAD, 32'hBEEF, 1'b0, 0, 1'b0, 0);
    tick();
    idle_bus();
    chk("t4_full_after_17th", 128'(bus.full), 128'(1));
    alu_cdb(9, 32'h99);
    for (int i = 0; i < 16; i++) push(3, i, 32'h99, 32'(i + 100));
    tick();
    idle_bus();
    chk("t4_full_before_dispatch", 128'(bus.full), 128'(1));
    tick();
    chk("t4_first_valid", 128'(bus.exe_valid), 128'(1));
    chk("t4_first_rob",   128'(bus.exe_rob_id), 128'(0));
    chk("t4_full_drops",  128'(bus.full), 128'(0));
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t4_order", 128'(bus.exe_rob_id), 128'(i));
    end
    tick();
    chk("t4_done", 128'(bus.exe_valid), 128'(0));

    // Flush with pending entries and a same-cycle issue
    for (int i = 0; i < 4; i++) begin
      issue(4, i, 32'h0, 32'h1, 1'b1, 12, 1'b0, 0);
      tick();
    end
    issue(4, 13, 32'h1, 32'h2, 1'b0, 0, 1'b0, 0);
    bus.clear = 1'b1;
    tick();
    idle_bus();
    chk("t5_valid", 128'(bus.exe_valid), 128'(0));
    chk("t5_full",  128'(bus.full),      128'(0));
    alu_cdb(12, 32'h5);
    tick();
    idle_bus();
    tick();
    tick();
    chk("t5_no_dispatch", 128'(bus.exe_valid), 128'(0));

    // rdy_in low freezes everything
    issue(4, 1, 32'h55, 32'h66, 1'b0, 0, 1'b0, 0);
    tick();
    bus.rdy_in = 1'b0;
    issue(5, 7, 32'h1, 32'h1, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_valid", 128'(bus.exe_valid), 128'(0));
      chk("t6_frozen_rob",   128'(bus.exe_rob_id), 128'(15));
    end
    bus.rdy_in = 1'b1;
    idle_bus();
    push(4, 1, 32'h55, 32'h66);
    tick();
    chk("t6_resume_valid", 128'(bus.exe_valid), 128'(1));
    chk("t6_resume_rob",   128'(bus.exe_rob_id), 128'(1));
    tick();

    // Asynchronous reset mid-stream
    issue(5, 10, 32'hA, 32'hB, 1'b0, 0, 1'b0, 0);
    push(5, 10, 32'hA, 32'hB);
    tick();
    issue(5, 11, 32'hC, 32'hD, 1'b0, 0, 1'b0, 0);
    tick();
    idle_bus();
    chk("t7_pre_rst_valid", 128'(bus.exe_valid), 128'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", 128'(bus.exe_valid), 128'(0));
    chk("t7_rst_rob",   128'(bus.exe_rob_id), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t7_entries_gone", 128'(bus.exe_valid), 128'(0));
    chk("t7_full", 128'(bus.full), 128'(0));

    chk("queue_drained", 128'(q_exp.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
